// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780-style write sequencer driven by a memory-mapped LCD word.
//
// A change of the low ten bits of the LCD word (RS, RW, DATA) is treated as a
// new write request. Each request is played out as SETUP -> EN_HI -> HOLD ->
// EXEC, with the execute wait lengthened for clear/home commands. One request
// can be queued while a transfer is running; a newer one replaces it.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       reset, asynchronous, active-high
//   i_lcd_word  [31]=ON, [9]=RS, [8]=RW, [7:0]=DATA, other bits ignored
//   o_lcd_on    registered copy of i_lcd_word[31]
//   o_lcd_en    enable strobe
//   o_lcd_rs    register select, held for the whole transfer
//   o_lcd_rw    read/write, tied to write (0)
//   o_lcd_data  data bus, held for the whole transfer
//   o_busy      high while a transfer runs or a request is queued
//   o_done      one-cycle pulse when a transfer's execute wait ends
module lcd_ctrl #(
  parameter int P_SETUP     = 2,
  parameter int P_EN        = 12,
  parameter int P_HOLD      = 2,
  parameter int P_EXEC      = 2000,
  parameter int P_EXEC_LONG = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lcd_word,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CW = (P_EXEC_LONG < 1) ? 1 : $clog2(P_EXEC_LONG + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_EN_HI = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;

  // Counter load for a phase of p cycles; a zero-length phase still takes one.
  function automatic logic [CW-1:0] load_val(input int p);
    int n;
    n = (p < 1) ? 1 : p;
    return CW'(n - 1);
  endfunction

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [9:0]    last_reg;
  logic [9:0]    pend_word_reg;
  logic          pend_reg;
  logic          primed_reg;
  logic          on_reg;
  logic          en_reg;
  logic          rs_reg;
  logic [7:0]    data_reg;
  logic          done_reg;

  logic req;
  logic long_cmd;

  // Until the first cycle after reset has sampled the word, nothing counts as
  // a change: the word already on the register becomes the baseline, so a
  // reset never replays the command that happened to be sitting there.
  assign req = primed_reg && (i_lcd_word[9:0] != last_reg);

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign long_cmd = !rs_reg && (data_reg == 8'h01 || data_reg == 8'h02 || data_reg == 8'h03);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      last_reg      <= '0;
      pend_word_reg <= '0;
      pend_reg      <= 1'b0;
      primed_reg    <= 1'b0;
      on_reg        <= 1'b0;
      en_reg        <= 1'b0;
      rs_reg        <= 1'b0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      on_reg   <= i_lcd_word[31];
      done_reg <= 1'b0;

      if (!primed_reg) begin
        primed_reg <= 1'b1;
        last_reg   <= i_lcd_word[9:0];
      end else if (req) begin
        last_reg <= i_lcd_word[9:0];
      end

      case (state_reg)
        S_IDLE: begin
          if (req || pend_reg) begin
            // A fresh change is newer than anything queued, so it wins.
            rs_reg    <= req ? i_lcd_word[9]   : pend_word_reg[9];
            data_reg  <= req ? i_lcd_word[7:0] : pend_word_reg[7:0];
            pend_reg  <= 1'b0;
            state_reg <= S_SETUP;
            cnt_reg   <= load_val(P_SETUP);
          end
        end
        S_SETUP: begin
          if (cnt_reg == '0) begin
            state_reg <= S_EN_HI;
            en_reg    <= 1'b1;
            cnt_reg   <= load_val(P_EN);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_EN_HI: begin
          if (cnt_reg == '0) begin
            state_reg <= S_HOLD;
            en_reg    <= 1'b0;
            cnt_reg   <= load_val(P_HOLD);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= S_EXEC;
            cnt_reg   <= long_cmd ? load_val(P_EXEC_LONG) : load_val(P_EXEC);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_EXEC: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          en_reg    <= 1'b0;
        end
      endcase

      // Outside IDLE a change is queued, overwriting any older queued word.
      // This includes the last EXEC cycle, so it starts on the next IDLE cycle.
      if (req && state_reg != S_IDLE) begin
        pend_reg      <= 1'b1;
        pend_word_reg <= i_lcd_word[9:0];
      end
    end
  end

  assign o_lcd_on   = on_reg;
  assign o_lcd_en   = en_reg;
  assign o_lcd_rs   = rs_reg;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_reg;
  assign o_busy     = (state_reg != S_IDLE) || pend_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl -- directed bench for lcd_ctrl with shortened timing
// (P_SETUP=2, P_EN=4, P_HOLD=2, P_EXEC=10, P_EXEC_LONG=50).
//
// Cycle numbering: a word is applied just after edge 0; "cycle c" is the
// sample taken 1 time unit after the c-th following rising edge. With these
// parameters a normal transfer shows EN high in cycles 3..6 and o_done in
// cycle 19; a clear/home transfer shows o_done in cycle 59.
module tb_lcd_ctrl;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_lcd_word;
  logic        o_lcd_on;
  logic        o_lcd_en;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic [7:0]  o_lcd_data;
  logic        o_busy;
  logic        o_done;

  int n_cmp = 0;
  int n_err = 0;
  logic seen_0c = 1'b0;

  lcd_ctrl #(
    .P_SETUP(2), .P_EN(4), .P_HOLD(2), .P_EXEC(10), .P_EXEC_LONG(50)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lcd_word(i_lcd_word),
    .o_lcd_on(o_lcd_on), .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs),
    .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data), .o_busy(o_busy),
    .o_done(o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_lcd_data == 8'h0C) seen_0c = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps up to budget cycles, stopping at the first o_done. Records the first
  // cycle EN is seen high, the number of EN-high cycles, the done cycle, the
  // RS/DATA seen at the first EN cycle, and whether RS/DATA moved afterwards.
  task automatic observe(input int budget, output int en_rise, output int en_cnt,
                         output int done_at, output logic [7:0] d, output logic r,
                         output logic moved);
    en_rise = -1; en_cnt = 0; done_at = -1; d = 8'h00; r = 1'b0; moved = 1'b0;
    for (int c = 1; c <= budget && done_at < 0; c++) begin
      tick();
      if (en_rise >= 0 && (o_lcd_data !== d || o_lcd_rs !== r)) moved = 1'b1;
      if (o_lcd_en) begin
        if (en_rise < 0) begin
          en_rise = c; d = o_lcd_data; r = o_lcd_rs;
        end
        en_cnt++;
      end
      if (o_done) done_at = c;
    end
  endtask

  int er, ec, da;
  logic [7:0] dd;
  logic rr, mv;

  initial begin
    // Reset state
    i_rst = 1'b1;
    i_lcd_word = 32'h8000_0000;
    repeat (3) tick();
    chk("rst_on",   {31'd0, o_lcd_on},   32'd0);
    chk("rst_en",   {31'd0, o_lcd_en},   32'd0);
    chk("rst_rs",   {31'd0, o_lcd_rs},   32'd0);
    chk("rst_rw",   {31'd0, o_lcd_rw},   32'd0);
    chk("rst_data", {24'd0, o_lcd_data}, 32'd0);
    chk("rst_busy", {31'd0, o_busy},     32'd0);
    chk("rst_done", {31'd0, o_done},     32'd0);
    i_lcd_word = 32'h0;
    #2 i_rst = 1'b0;
    observe(12, er, ec, da, dd, rr, mv);
    chk("zero_word_no_en", ec, 0);
    chk("zero_word_busy", {31'd0, o_busy}, 32'd0);

    // 'A' with RS=1
    i_lcd_word = 32'h0000_0241;
    observe(100, er, ec, da, dd, rr, mv);
    $display("xfer 0x241: en_rise=%0d en_cycles=%0d done=%0d rs=%0d data=%0h", er, ec, da, rr, dd);
    chk("a_en_rise", er, 3);
    chk("a_en_len", ec, 4);
    chk("a_done", da, 19);
    chk("a_rs", {31'd0, rr}, 32'd1);
    chk("a_data", {24'd0, dd}, 32'h41);
    chk("a_stable", {31'd0, mv}, 32'd0);
    tick();
    chk("a_busy_after", {31'd0, o_busy}, 32'd0);

    // Clear display: long execute wait
    i_lcd_word = 32'h0000_0001;
    observe(200, er, ec, da, dd, rr, mv);
    $display("xfer 0x001: en_rise=%0d en_cycles=%0d done=%0d rs=%0d data=%0h", er, ec, da, rr, dd);
    chk("clr_en_rise", er, 3);
    chk("clr_done", da, 59);
    chk("clr_rs", {31'd0, rr}, 32'd0);
    chk("clr_data", {24'd0, dd}, 32'h01);

    // Only the RW bit changes: still a request, still a write, still long
    i_lcd_word = 32'h0000_0101;
    observe(200, er, ec, da, dd, rr, mv);
    $display("xfer 0x101: en_rise=%0d done=%0d rw=%0d", er, da, o_lcd_rw);
    chk("rw_done", da, 59);
    chk("rw_out", {31'd0, o_lcd_rw}, 32'd0);

    // 0x04 with RS=0 is just above the long-command range
    i_lcd_word = 32'h0000_0004;
    observe(200, er, ec, da, dd, rr, mv);
    $display("xfer 0x004: en_rise=%0d done=%0d data=%0h", er, da, dd);
    chk("e4_done", da, 19);

    // Three writes while busy: only the newest is sent
    i_lcd_word = 32'h0000_0241;
    repeat (3) tick();
    i_lcd_word = 32'h0000_0038;
    tick();
    i_lcd_word = 32'h0000_000C;
    tick();
    i_lcd_word = 32'h0000_0006;
    observe(100, er, ec, da, dd, rr, mv);
    $display("xfer 0x241 (busy writes): done=%0d data=%0h busy=%0d", da, dd, o_busy);
    chk("ow_first_done", da, 14);
    chk("ow_first_data", {24'd0, dd}, 32'h41);
    chk("ow_pending_busy", {31'd0, o_busy}, 32'd1);
    observe(100, er, ec, da, dd, rr, mv);
    $display("xfer pending: en_rise=%0d done=%0d rs=%0d data=%0h", er, da, rr, dd);
    chk("ow_en_rise", er, 3);
    chk("ow_done", da, 19);
    chk("ow_data", {24'd0, dd}, 32'h06);
    chk("ow_rs", {31'd0, rr}, 32'd0);
    observe(30, er, ec, da, dd, rr, mv);
    chk("ow_no_more_en", ec, 0);
    chk("ow_never_0c", {31'd0, seen_0c}, 32'd0);

    // Change arriving on the last EXEC cycle
    i_lcd_word = 32'h0000_0041;
    observe(18, er, ec, da, dd, rr, mv);
    chk("late_no_done_yet", da, -1);
    i_lcd_word = 32'h0000_0042;
    observe(5, er, ec, da, dd, rr, mv);
    chk("late_done", da, 1);
    chk("late_busy", {31'd0, o_busy}, 32'd1);
    observe(100, er, ec, da, dd, rr, mv);
    $display("xfer late 0x042: en_rise=%0d done=%0d data=%0h", er, da, dd);
    chk("late_en_rise", er, 3);
    chk("late_data", {24'd0, dd}, 32'h42);
    chk("late_done2", da, 19);

    // Reset during EN_HI
    i_lcd_word = 32'h0000_0243;
    repeat (4) tick();
    chk("mid_en_high", {31'd0, o_lcd_en}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_en_async", {31'd0, o_lcd_en}, 32'd0);
    chk("mid_data", {24'd0, o_lcd_data}, 32'd0);
    chk("mid_busy", {31'd0, o_busy}, 32'd0);
    repeat (2) tick();
    #2 i_rst = 1'b0;
    observe(40, er, ec, da, dd, rr, mv);
    $display("after reset with unchanged word: en_cycles=%0d done=%0d", ec, da);
    chk("post_rst_no_en", ec, 0);
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // ON bit alone
    i_lcd_word = 32'h8000_0243;
    chk("on_pre", {31'd0, o_lcd_on}, 32'd0);
    tick();
    chk("on_set", {31'd0, o_lcd_on}, 32'd1);
    chk("on_busy", {31'd0, o_busy}, 32'd0);
    observe(30, er, ec, da, dd, rr, mv);
    chk("on_no_en", ec, 0);
    i_lcd_word = 32'h0000_0243;
    tick();
    chk("on_clear", {31'd0, o_lcd_on}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
